serial_adder_seq: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/openlane_full_adder.sv | 13 +
 rtl/serial_adder_seq.sv | 141 ++++++++++++++
 tb/tb_serial_adder_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state
// encoding and the supported operand-width range.
package serial_adder_pkg;

    // Supported operand widths (inclusive)
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when a requested operand width is within the supported range
    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/openlane_full_adder.sv
// Single-bit combinational full-adder cell.
module openlane_full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic c,
    output logic carry_out
);

    assign c         = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer: feeds one operand bit pair per clock, LSB
// first, into a single full-adder cell and assembles the parallel result.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_adder_seq: WIDTH out of supported range");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    // Only WIDTH-1 partial bits need storing: the last bit comes straight
    // from the adder on the completing edge.
    logic [WIDTH-2:0]   res_sr_q, res_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   res_shift;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    openlane_full_adder u_fa (
        .a         (a_sr_q[0]),
        .b         (b_sr_q[0]),
        .carry_in  (carry_q),
        .c         (fa_sum),
        .carry_out (fa_cout)
    );

    // New sum bit enters at the MSB; the full vector is the final result
    assign res_shift = {fa_sum, res_sr_q};

    // Operand B and carry as loaded on an accepted start (subtract inverts B
    // and forces carry-in so the adder computes A + ~B + 1)
    always_comb begin
        b_load     = b_in;
        carry_load = cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load     = ~b_in;
            carry_load = 1'b1;
        end
`endif
    end

    // Next-state logic: FSM, shift registers, counter and result capture
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sr_d   = a_in;
                    b_sr_d   = b_load;
                    carry_d  = carry_load;
                    res_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_shift[WIDTH-1:1];
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_shift;
                    cout_d  = fa_cout;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; partial work is discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq at WIDTH=8 and WIDTH=16.
// Subtract checks are included when SERIAL_ADD_SUB_EN is defined.
module tb_serial_adder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, cin8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        start16, cin16, sub16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    int nvec = 0;
    int nerr = 0;

    serial_adder_seq #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a_in  (a8),
        .b_in  (b8),
        .cin   (cin8),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_seq #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (start16),
        .a_in  (a16),
        .b_in  (b16),
        .cin   (cin16),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub16),
`endif
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {cout,sum} = a + b + cin, or a - b with cout = no-borrow
    function automatic logic [8:0] ref8(input logic [7:0] a, b, input logic c, s);
        bit sub_on;
`ifdef SERIAL_ADD_SUB_EN
        sub_on = s;
`else
        sub_on = 1'b0;
`endif
        if (sub_on) return {(a >= b), 8'(a - b)};
        return {1'b0, a} + {1'b0, b} + 9'(c);
    endfunction

    function automatic logic [16:0] ref16(input logic [15:0] a, b, input logic c, s);
        bit sub_on;
`ifdef SERIAL_ADD_SUB_EN
        sub_on = s;
`else
        sub_on = 1'b0;
`endif
        if (sub_on) return {(a >= b), 16'(a - b)};
        return {1'b0, a} + {1'b0, b} + 17'(c);
    endfunction

    // One complete 8-bit operation; optionally checks the cycle after done
    task automatic run8(input logic [7:0] a, b, input logic c, s, input bit tail);
        logic [8:0] exp;
        exp = ref8(a, b, c, s);
        a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        for (int k = 0; k < 8; k++) begin
            nvec++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                nerr++;
                $display("FAIL busy8 cyc%0d: busy=%b done=%b expected busy=1 done=0", k, busy8, done8);
            end
            tick();
        end
        nvec++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            nerr++;
            $display("FAIL done8: done=%b busy=%b expected done=1 busy=0", done8, busy8);
        end
        nvec++;
        if ({cout8, sum8} !== exp) begin
            nerr++;
            $display("FAIL result8 a=%h b=%h c=%b s=%b: got %h expected %h", a, b, c, s, {cout8, sum8}, exp);
        end
        $display("w8  a=%h b=%h cin=%b sub=%b -> cout=%b sum=%h", a, b, c, s, cout8, sum8);
        if (tail) begin
            tick();
            nvec++;
            if (done8 !== 1'b0 || {cout8, sum8} !== exp) begin
                nerr++;
                $display("FAIL pulse8: done=%b res=%h expected done=0 res=%h", done8, {cout8, sum8}, exp);
            end
        end
    endtask

    task automatic run16(input logic [15:0] a, b, input logic c, s, input bit tail);
        logic [16:0] exp;
        exp = ref16(a, b, c, s);
        a16 = a; b16 = b; cin16 = c; sub16 = s; start16 = 1'b1;
        tick();
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
        for (int k = 0; k < 16; k++) begin
            nvec++;
            if (busy16 !== 1'b1 || done16 !== 1'b0) begin
                nerr++;
                $display("FAIL busy16 cyc%0d: busy=%b done=%b expected busy=1 done=0", k, busy16, done16);
            end
            tick();
        end
        nvec++;
        if (done16 !== 1'b1 || busy16 !== 1'b0) begin
            nerr++;
            $display("FAIL done16: done=%b busy=%b expected done=1 busy=0", done16, busy16);
        end
        nvec++;
        if ({cout16, sum16} !== exp) begin
            nerr++;
            $display("FAIL result16 a=%h b=%h c=%b s=%b: got %h expected %h", a, b, c, s, {cout16, sum16}, exp);
        end
        $display("w16 a=%h b=%h cin=%b sub=%b -> cout=%b sum=%h", a, b, c, s, cout16, sum16);
        if (tail) begin
            tick();
            nvec++;
            if (done16 !== 1'b0 || {cout16, sum16} !== exp) begin
                nerr++;
                $display("FAIL pulse16: done=%b res=%h expected done=0 res=%h", done16, {cout16, sum16}, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        nvec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            nerr++;
            $display("FAIL reset8: busy=%b done=%b cout=%b sum=%h expected all 0", busy8, done8, cout8, sum8);
        end
        nvec++;
        if ({busy16, done16, cout16, sum16} !== 19'd0) begin
            nerr++;
            $display("FAIL reset16: busy=%b done=%b cout=%b sum=%h expected all 0", busy16, done16, cout16, sum16);
        end
    endtask

    task automatic test_directed();
        run8(8'h5A, 8'h33, 1'b0, 1'b0, 1'b1);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_subtract();
`ifdef SERIAL_ADD_SUB_EN
        run8(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
        run8(8'h01, 8'h02, 1'b1, 1'b1, 1'b1);
        run16(16'h0100, 16'h0100, 1'b0, 1'b1, 1'b1);
`endif
    endtask

    // Start during RUN is ignored; start in the DONE cycle is accepted
    task automatic test_back_to_back();
        int n;
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'hF0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        nvec++;
        if (done8 !== 1'b1 || {cout8, sum8} !== 9'h002) begin
            nerr++;
            $display("FAIL ignore_start: done=%b res=%h expected done=1 res=002", done8, {cout8, sum8});
        end
        $display("w8  a=01 b=01 (start during RUN) -> cout=%b sum=%h", cout8, sum8);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 1;
        while (done8 !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        nvec++;
        if (n !== 9 || {cout8, sum8} !== 9'h030) begin
            nerr++;
            $display("FAIL b2b: edges=%0d res=%h expected edges=9 res=030", n, {cout8, sum8});
        end
        $display("w8  a=10 b=20 (start in DONE) -> cout=%b sum=%h after %0d edges", cout8, sum8, n);
    endtask

    // Reset mid-RUN clears outputs and no done pulse follows
    task automatic test_reset_mid_run();
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        nvec++;
        if (busy8 !== 1'b1) begin
            nerr++;
            $display("FAIL midrun_busy: busy=%b expected 1", busy8);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            nerr++;
            $display("FAIL midrun_reset: busy=%b done=%b cout=%b sum=%h expected all 0", busy8, done8, cout8, sum8);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            nvec++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                nerr++;
                $display("FAIL no_done_after_reset cyc%0d: done=%b busy=%b expected 0 0", k, done8, busy8);
            end
        end
        $display("w8  reset during RUN -> idle, sum=%h cout=%b", sum8, cout8);
    endtask

    task automatic test_random8();
        for (int i = 0; i < 1000; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        tick();
    endtask

    task automatic test_random16();
        for (int i = 0; i < 1000; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        test_reset();
        test_directed();
        test_subtract();
        test_back_to_back();
        test_reset_mid_run();
        test_random8();
        test_random16();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
